// File: rtl/mult_div_unit_32.sv
// ---------------------------------------------------------------------------
// mult_div_unit_32
//
// Iterative radix-2 multiply/divide unit that owns the architectural HI/LO
// registers. Operands come straight from the register-file read ports and are
// captured on the start edge. The unit runs 32 iterations, then spends one
// fix-up cycle applying the sign and committing HI/LO.
//
// Ports:
//   clk      in   1   system clock, rising edge
//   rst_n    in   1   synchronous active-low reset
//   start    in   1   begin operation selected by op (IDLE only)
//   op       in   2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rs_data  in   32  operand A (multiplicand / dividend), MTHI/MTLO source
//   rt_data  in   32  operand B (multiplier / divisor)
//   mthi     in   1   HI <= rs_data (IDLE only, start has priority)
//   mtlo     in   1   LO <= rs_data (IDLE only, start has priority)
//   busy     out  1   state != IDLE
//   done     out  1   one-cycle pulse when a new result is in HI/LO
//   hi       out  32  HI register (upper product / remainder)
//   lo       out  32  LO register (lower product / quotient)
// ---------------------------------------------------------------------------
module mult_div_unit_32 #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] rs_data,
    input  logic [DATA_WIDTH-1:0] rt_data,
    input  logic                  mthi,
    input  logic                  mtlo,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    localparam int W = DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t         state;
    logic [4:0]     cnt;
    logic           is_div;
    logic           neg_q;
    logic           neg_r;
    logic           div0;
    logic [W-1:0]   mcand;      // multiplicand (mult) or divisor (div) magnitude
    logic [W-1:0]   orig_a;     // raw rs_data, returned as HI on divide-by-zero
    logic [2*W-1:0] acc;        // mult: product/multiplier; div: {rem, quo}
    logic           done_r;
    logic [W-1:0]   hi_r;
    logic [W-1:0]   lo_r;

    // Operand magnitudes for the start capture. Negating 0x80000000 yields
    // 0x80000000, which the unsigned datapath treats as 2^31.
    logic         signed_op;
    logic         a_neg;
    logic         b_neg;
    logic [W-1:0] mag_a;
    logic [W-1:0] mag_b;

    assign signed_op = ~op[0];
    assign a_neg     = signed_op & rs_data[W-1];
    assign b_neg     = signed_op & rt_data[W-1];
    assign mag_a     = a_neg ? (~rs_data + 1'b1) : rs_data;
    assign mag_b     = b_neg ? (~rt_data + 1'b1) : rt_data;

    // Shift-add step: conditional add into the upper half with a carry bit,
    // then shift the whole accumulator (carry included) right by one.
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;

    assign mul_sum  = {1'b0, acc[2*W-1:W]} + {1'b0, mcand};
    assign mul_next = acc[0] ? {mul_sum, acc[W-1:1]}
                             : {1'b0, acc[2*W-1:1]};

    // Restoring division step. The remainder stays below the divisor, so
    // when the trial subtract goes negative the shifted value fits in W bits.
    logic [W:0]     div_sh;
    logic [W:0]     div_diff;
    logic [2*W-1:0] div_next;

    assign div_sh   = {acc[2*W-1:W], acc[W-1]};
    assign div_diff = div_sh - {1'b0, mcand};
    assign div_next = div_diff[W] ? {div_sh[W-1:0],   acc[W-2:0], 1'b0}
                                  : {div_diff[W-1:0], acc[W-2:0], 1'b1};

    // Sign fix-up values used in FIX.
    logic [2*W-1:0] acc_neg;
    logic [W-1:0]   quo_neg;
    logic [W-1:0]   rem_neg;

    assign acc_neg = ~acc + 1'b1;
    assign quo_neg = ~acc[W-1:0] + 1'b1;
    assign rem_neg = ~acc[2*W-1:W] + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            mcand  <= '0;
            orig_a <= '0;
            acc    <= '0;
            done_r <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div <= op[1];
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        div0   <= op[1] & (rt_data == '0);
                        orig_a <= rs_data;
                        mcand  <= op[1] ? mag_b : mag_a;
                        // mult: multiplier in the low half; div: dividend
                        // in the low half (quotient shifts in behind it)
                        acc    <= {{W{1'b0}}, (op[1] ? mag_a : mag_b)};
                        cnt    <= '0;
                        state  <= RUN;
                    end else begin
                        if (mthi) hi_r <= rs_data;
                        if (mtlo) lo_r <= rs_data;
                    end
                end
                RUN: begin
                    acc <= is_div ? div_next : mul_next;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= FIX;
                end
                FIX: begin
                    if (!is_div) begin
                        {hi_r, lo_r} <= neg_q ? acc_neg : acc;
                    end else if (div0) begin
                        hi_r <= orig_a;
                        lo_r <= '1;
                    end else begin
                        lo_r <= neg_q ? quo_neg : acc[W-1:0];
                        hi_r <= neg_r ? rem_neg : acc[2*W-1:W];
                    end
                    done_r <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_mult_div_unit_32.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit_32
//
// Scoreboard bench: each started operation pushes its expected {HI,LO} from a
// 64-bit arithmetic model; a monitor pops and compares on every done pulse.
// Directed cases cover signed/unsigned corners, divide-by-zero, overflow,
// MTHI/MTLO, inputs ignored while busy and reset mid-operation.
// ---------------------------------------------------------------------------
module tb_mult_div_unit_32;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    mult_div_unit_32 #(.DATA_WIDTH(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [63:0] sb[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: {HI, LO} from plain 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb_, q, r;
        logic [63:0] ua, ub, p;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        case (o)
            2'b00: p = sa * sb_;
            2'b01: p = ua * ub;
            2'b10: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb_;
                    r = sa % sb_;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else p = {(ua % ub) * 64'd1, 64'd0} >> 0 == 0 ? 64'd0 : {(ua % ub), 32'b0} >> 0;
            end
        endcase
        if (o == 2'b11 && b != 32'd0) begin
            p[63:32] = 32'(ua % ub);
            p[31:0]  = 32'(ua / ub);
        end
        return p;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding operation.
    always @(negedge clk) begin
        logic [63:0] e;
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) chk("done_spurious", 64'd1, 64'd0);
            else begin
                e = sb.pop_front();
                chk("hi", {32'b0, hi}, {32'b0, e[63:32]});
                chk("lo", {32'b0, lo}, {32'b0, e[31:0]});
            end
        end
    end

    // inj: 0 none, 1 MTHI while busy, 2 start while busy, 3 MTHI with start
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int inj);
        logic [31:0] hold_hi;
        int          cnt;
        @(negedge clk);
        start   = 1'b1;
        op      = o;
        rs_data = a;
        rt_data = b;
        mthi    = (inj == 3);
        sb.push_back(model(o, a, b));
        hold_hi = hi;
        @(negedge clk);
        start   = 1'b0;
        mthi    = 1'b0;
        op      = 2'($urandom);
        rs_data = $urandom;
        rt_data = $urandom;
        cnt     = 0;
        while (busy === 1'b1 && cnt < 60) begin
            if (cnt == 5) begin
                if (inj == 1) begin
                    mthi    = 1'b1;
                    rs_data = 32'hDEAD_BEEF;
                end
                if (inj == 2) begin
                    start   = 1'b1;
                    op      = 2'b01;
                    rs_data = 32'd9;
                    rt_data = 32'd9;
                end
            end
            if (cnt == 6) begin
                mthi  = 1'b0;
                start = 1'b0;
                chk("hold_hi", {32'b0, hi}, {32'b0, hold_hi});
            end
            cnt++;
            @(negedge clk);
        end
        chk("latency", 64'(cnt), 64'd33);
        chk("done_pulse", {63'b0, done}, 64'd1);
        @(negedge clk);
        chk("done_clear", {63'b0, done}, 64'd0);
        chk("idle", {63'b0, busy}, 64'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        op      = 2'b00;
        rs_data = 32'h0;
        rt_data = 32'h0;
        mthi    = 1'b0;
        mtlo    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_hi",   {32'b0, hi},   64'd0);
        chk("rst_lo",   {32'b0, lo},   64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
        rst_n = 1'b1;

        // directed arithmetic corners
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0);           // -3 * 7
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0);           // -7 / 2
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);   // overflow
        run_op(2'b11, 32'd100, 32'd0, 0);                 // DIVU by zero
        run_op(2'b10, 32'hFFFF_FF9C, 32'd0, 0);           // DIV -100 by zero
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0);
        run_op(2'b11, 32'hFFFF_FFFF, 32'd1, 0);

        // MTHI + MTLO together while idle
        @(negedge clk);
        mthi    = 1'b1;
        mtlo    = 1'b1;
        rs_data = 32'h1234_5678;
        @(negedge clk);
        mthi = 1'b0;
        mtlo = 1'b0;
        chk("mthi", {32'b0, hi}, 64'h1234_5678);
        chk("mtlo", {32'b0, lo}, 64'h1234_5678);
        chk("mt_no_done", {63'b0, done}, 64'd0);

        // MTHI alone
        rs_data = 32'hCAFE_0001;
        mthi    = 1'b1;
        @(negedge clk);
        mthi = 1'b0;
        chk("mthi_only_hi", {32'b0, hi}, 64'hCAFE_0001);
        chk("mthi_only_lo", {32'b0, lo}, 64'h1234_5678);

        // inputs ignored while busy / start priority
        run_op(2'b01, 32'd3, 32'd4, 1);
        run_op(2'b00, 32'd11, 32'hFFFF_FFFE, 2);
        run_op(2'b11, 32'd1000, 32'd7, 3);

        // random operations
        for (int i = 0; i < 8; i++) begin
            logic [31:0] b;
            b = $urandom;
            if (i == 3) b = 32'd0;
            run_op(2'($urandom_range(0, 3)), $urandom, b, 0);
        end

        // reset mid-operation abandons the operation
        @(negedge clk);
        start   = 1'b1;
        op      = 2'b01;
        rs_data = 32'd5;
        rt_data = 32'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_busy", {63'b0, busy}, 64'd0);
        chk("mid_rst_hi",   {32'b0, hi},   64'd0);
        chk("mid_rst_lo",   {32'b0, lo},   64'd0);
        chk("mid_rst_done", {63'b0, done}, 64'd0);
        repeat (40) @(negedge clk);
        chk("after_rst_hi", {32'b0, hi}, 64'd0);

        // a normal operation still works after the abandoned one
        run_op(2'b01, 32'd5, 32'd6, 0);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mult_div_unit_32.md
# mult_div_unit_32

Iterative multiply/divide unit that takes its operands directly from the register file read ports (`ReadData1` → `rs_data`, `ReadData2` → `rt_data`). It holds the architectural HI/LO registers for MULT, MULTU, DIV, DIVU, MTHI and MTLO. Each operation runs radix-2 over 32 iterations. Control logic holds further HI/LO-dependent instructions while `busy` is high.

## Interface
Parameters:
- DATA_WIDTH, 32, operand and HI/LO width. Only 32 is supported and verified.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- start  in  1  begins the operation selected by `op`. Sampled only in IDLE.
- op  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rs_data  in  32  operand A (multiplicand/dividend). Also the MTHI/MTLO source.
- rt_data  in  32  operand B (multiplier/divisor).
- mthi  in  1  write `rs_data` into HI. Sampled only in IDLE.
- mtlo  in  1  write `rs_data` into LO. Sampled only in IDLE.
- busy  out  1  high whenever the state is not IDLE. Combinational from state.
- done  out  1  registered one-cycle pulse in the cycle in which new HI/LO values are visible.
- hi  out  32  HI register (upper product / remainder).
- lo  out  32  LO register (lower product / quotient).

## Operation
- **States:**
  - IDLE → RUN on `start`.
  - RUN → FIX after the 32nd iteration.
  - FIX → IDLE unconditionally.
- **Start capture (at the edge that samples `start`):**
  - Latch `op` and `rs_data`/`rt_data`.
  - For signed ops (MULT, DIV), latch the operand magnitudes: two's-complement negate if the MSB is set. 0x80000000 stays 0x80000000 and is treated as unsigned 2^31.
  - Record `neg_q` = signA XOR signB and `neg_r` = signA. Both are forced to 0 for unsigned ops.
  - Clear the 5-bit iteration counter.
- **RUN, multiply:** shift-add on a 64-bit accumulator. Each cycle, if acc[0] is set, add the multiplicand into acc[64:32] (33-bit carry), then shift right by 1.
- **RUN, divide:** restoring division. Each cycle, shift {rem, quo} left by 1 and trial-subtract the divisor from the 33-bit remainder. If non-negative, keep the difference and set the quotient LSB.
- **Counter:** increments every RUN cycle. When the counter reads 31, the state goes to FIX.
- **FIX, multiply:**
  - {HI,LO} = `neg_q` ? −acc (64-bit negate) : acc.
- **FIX, divide:**
  - LO = `neg_q` ? −quo : quo.
  - HI = `neg_r` ? −rem : rem.
- **Divide by zero (`rt_data` = 0), DIV or DIVU:**
  - Still takes full latency.
  - HI = original `rs_data` (unsigned and signed alike).
  - LO = 0xFFFFFFFF.
  - Sign fix is not applied.
- **Overflow case:** DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
- **Priority in IDLE:**
  - `start` wins over `mthi`/`mtlo`; when `start` is high, both are ignored.
  - `mthi` and `mtlo` may be asserted together; both writes then happen.
- **While busy:** `start`, `mthi` and `mtlo` are ignored. HI/LO hold their old values until FIX.

## Timing
- **Reset:** `rst_n` = 0 at an edge forces:
  - state IDLE, counter 0;
  - `hi` = 0, `lo` = 0;
  - `done` = 0, `busy` = 0.
  - Reset applied mid-operation abandons the operation; HI/LO become 0, not the partial result.
- **Operation timeline** (edge E0 samples `start`):
  - `busy` = 1 after E0.
  - RUN iterations occur at E1..E32.
  - FIX commits HI/LO at E33. After E33: `done` = 1, `busy` = 0, and new `hi`/`lo` are valid.
  - Total latency is 33 cycles from start edge to results. Earliest next `start` is sampled at E33+1.
- **`done`:** high for exactly one cycle per completed operation. It is never set by MTHI/MTLO.
- **MTHI/MTLO:** single-cycle. The new value is visible immediately after the sampling edge.
- **Operand hold:** `rs_data`/`rt_data` need only be valid at the start edge. They are don't-care afterwards.

## Test plan
- MULT rs = 0xFFFFFFFD (−3), rt = 7 → `busy` for 33 cycles; `done` pulse after E33; HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001. Repeat as MULT → HI = 0, LO = 1.
- DIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- DIVU 100 / 0 → after 33 cycles HI = 100, LO = 0xFFFFFFFF, `done` pulses once.
- MTHI 0x12345678 with MTLO in the same cycle (idle) → both registers = 0x12345678 after one edge, no `done`. Then MTHI asserted while busy → ignored; final HI is the op result.
- Start MULTU 5 × 6, then pulse `rst_n` low at E10 → `busy` = 0, HI = LO = 0, no `done`. Then `start` asserted at E5 of a fresh op → ignored; result matches the first op only.
